// File: rtl/motor_cmd_scheduler.sv
// Motor command scheduler: arbitrates line-follow and obstacle-avoid commands,
// forces a brake on the red marker, inserts coast dead-time on reversals and PWM-gates the enables.
module motor_cmd_scheduler #(
    parameter int DEAD_CYCLES = 16,
    parameter int STOP_HOLD   = 64,
    parameter int PWM_BITS    = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                red,
    input  logic                line_req,
    input  logic [3:0]          line_cmd,
    input  logic                avoid_req,
    input  logic [3:0]          avoid_cmd,
    input  logic [PWM_BITS-1:0] duty,
    output logic                line_gnt,
    output logic                avoid_gnt,
    output logic [3:0]          motorIn,
    output logic [1:0]          motorEn,
    output logic                busy,
    output logic [1:0]          state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DEAD = 2'b10,
        STOP = 2'b11
    } state_t;

    localparam logic [7:0]          DEAD_LAST = 8'(DEAD_CYCLES - 1);
    localparam logic [15:0]         STOP_LAST = 16'(STOP_HOLD - 1);
    localparam logic [PWM_BITS-1:0] PWM_TOP   = '1;
    localparam logic [PWM_BITS-1:0] PWM_ONE   = PWM_BITS'(1);

    state_t              state_reg, state_next;
    logic [3:0]          cur_cmd_reg, cur_cmd_next;
    logic [3:0]          pending_reg, pending_next;
    logic [7:0]          dead_cnt_reg, dead_cnt_next;
    logic [15:0]         hold_cnt_reg, hold_cnt_next;
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [PWM_BITS-1:0] duty_q_reg;
    logic                line_gnt_next, avoid_gnt_next;
    logic                pwm_on;
    logic                win_req;
    logic [3:0]          win_cmd;
    logic [1:0]          pair_rev;
    logic                win_rev;

    assign win_req = avoid_req | line_req;
    assign win_cmd = avoid_req ? avoid_cmd : line_cmd;

    // Only a forward<->reverse swap on a pair needs dead-time; coast/brake never do.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_pair
            assign pair_rev[gi] =
                ((cur_cmd_reg[2*gi +: 2] == 2'b10) && (win_cmd[2*gi +: 2] == 2'b01)) ||
                ((cur_cmd_reg[2*gi +: 2] == 2'b01) && (win_cmd[2*gi +: 2] == 2'b10));
        end
    endgenerate

    assign win_rev = |pair_rev;
    assign pwm_on  = (pwm_cnt_reg < duty_q_reg);
    assign state_o = state_reg;

    always_comb begin
        state_next     = state_reg;
        cur_cmd_next   = cur_cmd_reg;
        pending_next   = pending_reg;
        dead_cnt_next  = dead_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        line_gnt_next  = 1'b0;
        avoid_gnt_next = 1'b0;
        if (red) begin
            // Red overrides everything, including a dead-time completing this cycle.
            state_next    = STOP;
            pending_next  = 4'b0000;
            dead_cnt_next = 8'd0;
            hold_cnt_next = 16'd0;
        end else begin
            case (state_reg)
                IDLE, RUN: begin
                    if (win_req) begin
                        avoid_gnt_next = avoid_req;
                        line_gnt_next  = ~avoid_req;
                        if (win_rev) begin
                            pending_next  = win_cmd;
                            dead_cnt_next = 8'd0;
                            state_next    = DEAD;
                        end else begin
                            cur_cmd_next = win_cmd;
                            state_next   = RUN;
                        end
                    end
                end
                DEAD: begin
                    if (dead_cnt_reg == DEAD_LAST) begin
                        cur_cmd_next  = pending_reg;
                        pending_next  = 4'b0000;
                        dead_cnt_next = 8'd0;
                        state_next    = RUN;
                    end else begin
                        dead_cnt_next = dead_cnt_reg + 8'd1;
                    end
                end
                STOP: begin
                    if (hold_cnt_reg == STOP_LAST) begin
                        cur_cmd_next  = 4'b0000;
                        hold_cnt_next = 16'd0;
                        state_next    = IDLE;
                    end else begin
                        hold_cnt_next = hold_cnt_reg + 16'd1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            cur_cmd_reg  <= 4'b0000;
            pending_reg  <= 4'b0000;
            dead_cnt_reg <= 8'd0;
            hold_cnt_reg <= 16'd0;
            pwm_cnt_reg  <= '0;
            duty_q_reg   <= '0;
            line_gnt     <= 1'b0;
            avoid_gnt    <= 1'b0;
            busy         <= 1'b0;
            motorIn      <= 4'b0000;
            motorEn      <= 2'b00;
        end else begin
            state_reg    <= state_next;
            cur_cmd_reg  <= cur_cmd_next;
            pending_reg  <= pending_next;
            dead_cnt_reg <= dead_cnt_next;
            hold_cnt_reg <= hold_cnt_next;
            pwm_cnt_reg  <= pwm_cnt_reg + PWM_ONE;
            // Duty is only picked up at the period boundary so a period is never torn.
            if (pwm_cnt_reg == PWM_TOP) begin
                duty_q_reg <= duty;
            end
            line_gnt  <= line_gnt_next;
            avoid_gnt <= avoid_gnt_next;
            busy      <= (state_next == DEAD) || (state_next == STOP);
            case (state_next)
                RUN: begin
                    motorIn <= cur_cmd_next;
                    motorEn <= {2{pwm_on}};
                end
                STOP: begin
                    motorIn <= 4'b1111;
                    motorEn <= 2'b11;
                end
                default: begin
                    motorIn <= 4'b0000;
                    motorEn <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_motor_cmd_scheduler.sv
// Bench for motor_cmd_scheduler: directed scenarios plus a cycle-level behavioural model
// checked every cycle, and literal expectations that pin timing and PWM shape.
module tb_motor_cmd_scheduler;

    localparam int DEAD_CYCLES = 16;
    localparam int STOP_HOLD   = 64;
    localparam int PWM_BITS    = 8;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DEAD = 2;
    localparam int M_STOP = 3;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                red = 1'b0;
    logic                line_req = 1'b0;
    logic [3:0]          line_cmd = 4'b0000;
    logic                avoid_req = 1'b0;
    logic [3:0]          avoid_cmd = 4'b0000;
    logic [PWM_BITS-1:0] duty = '0;
    logic                line_gnt, avoid_gnt, busy;
    logic [3:0]          motorIn;
    logic [1:0]          motorEn;
    logic [1:0]          state_o;

    int checks = 0;
    int errors = 0;

    motor_cmd_scheduler #(
        .DEAD_CYCLES(DEAD_CYCLES),
        .STOP_HOLD  (STOP_HOLD),
        .PWM_BITS   (PWM_BITS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .red      (red),
        .line_req (line_req),
        .line_cmd (line_cmd),
        .avoid_req(avoid_req),
        .avoid_cmd(avoid_cmd),
        .duty     (duty),
        .line_gnt (line_gnt),
        .avoid_gnt(avoid_gnt),
        .motorIn  (motorIn),
        .motorEn  (motorEn),
        .busy     (busy),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Counts how many consecutive cycles (including the current one) the DUT stays in st.
    task automatic count_state(input logic [1:0] st, output int n);
        n = 1;
        for (int i = 0; i < 400; i++) begin
            step(1);
            if (state_o !== st) return;
            n++;
        end
        checks++;
        errors++;
        $display("FAIL timeout: still in state %0d after 400 cycles", st);
    endtask

    function automatic bit reverses(input int from, input int to);
        for (int p = 0; p < 2; p++) begin
            int a;
            int b;
            a = (from >> (2 * p)) & 3;
            b = (to >> (2 * p)) & 3;
            if ((a == 1 && b == 2) || (a == 2 && b == 1)) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Behavioural model: mode, current/pending command, remaining dead cycles, quiet-red count, PWM.
    int m_mode, m_cur, m_pend, m_left, m_quiet, m_cnt, m_dq, m_c;
    bit m_valid = 1'b0;
    bit en_now;
    int e_in, e_en, e_lg, e_ag, e_busy;

    always @(posedge clk) begin
        if (reset) begin
            m_mode = M_IDLE; m_cur = 0; m_pend = 0; m_left = 0; m_quiet = 0;
            m_cnt = 0; m_dq = 0;
            e_in = 0; e_en = 0; e_lg = 0; e_ag = 0; e_busy = 0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            en_now = (m_cnt < m_dq);
            if (m_cnt == (1 << PWM_BITS) - 1) m_dq = int'(duty);
            m_cnt = (m_cnt + 1) % (1 << PWM_BITS);
            e_lg = 0;
            e_ag = 0;
            if (red) begin
                m_mode = M_STOP; m_quiet = 0; m_pend = 0;
            end else if (m_mode == M_IDLE || m_mode == M_RUN) begin
                if (avoid_req || line_req) begin
                    if (avoid_req) begin e_ag = 1; m_c = int'(avoid_cmd); end
                    else begin e_lg = 1; m_c = int'(line_cmd); end
                    if (reverses(m_cur, m_c)) begin
                        m_pend = m_c; m_left = DEAD_CYCLES; m_mode = M_DEAD;
                    end else begin
                        m_cur = m_c; m_mode = M_RUN;
                    end
                end
            end else if (m_mode == M_DEAD) begin
                m_left--;
                if (m_left == 0) begin m_cur = m_pend; m_mode = M_RUN; end
            end else begin
                m_quiet++;
                if (m_quiet == STOP_HOLD) begin m_mode = M_IDLE; m_cur = 0; end
            end
            e_in   = (m_mode == M_RUN) ? m_cur : (m_mode == M_STOP) ? 15 : 0;
            e_en   = (m_mode == M_RUN) ? (en_now ? 3 : 0) : (m_mode == M_STOP) ? 3 : 0;
            e_busy = (m_mode == M_DEAD || m_mode == M_STOP) ? 1 : 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_state", 32'(state_o), 32'(m_mode));
            check("model_motorIn", 32'(motorIn), 32'(e_in));
            check("model_motorEn", 32'(motorEn), 32'(e_en));
            check("model_busy", 32'(busy), 32'(e_busy));
            check("model_line_gnt", 32'(line_gnt), 32'(e_lg));
            check("model_avoid_gnt", 32'(avoid_gnt), 32'(e_ag));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, hi, nz, run, maxrun;
        logic [1:0] prev;

        // Reset values
        step(3);
        check("rst_state", 32'(state_o), 32'(2'b00));
        check("rst_motorIn", 32'(motorIn), 32'(4'b0000));
        check("rst_motorEn", 32'(motorEn), 32'(2'b00));
        check("rst_busy", 32'(busy), 32'(1'b0));
        check("rst_gnt", 32'({line_gnt, avoid_gnt}), 32'(2'b00));

        // Line request from IDLE, full duty
        reset = 1'b0; duty = 8'hFF; line_req = 1'b1; line_cmd = 4'b1010;
        step(1);
        check("run_line_gnt", 32'(line_gnt), 32'(1'b1));
        check("run_motorIn", 32'(motorIn), 32'(4'b1010));
        check("run_state", 32'(state_o), 32'(2'b01));
        line_req = 1'b0;
        step(300);
        hi = 0; nz = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (motorEn == 2'b11) hi++;
            else if (motorEn == 2'b00) nz++;
        end
        check("ff_en_high_cycles", 32'(hi), 32'd255);
        check("ff_en_low_cycles", 32'(nz), 32'd1);

        // Simultaneous requests, avoid wins with a double reversal
        line_req = 1'b1; line_cmd = 4'b1010; avoid_req = 1'b1; avoid_cmd = 4'b0101;
        step(1);
        check("arb_avoid_gnt", 32'(avoid_gnt), 32'(1'b1));
        check("arb_line_gnt", 32'(line_gnt), 32'(1'b0));
        check("arb_state_dead", 32'(state_o), 32'(2'b10));
        check("arb_motorIn", 32'(motorIn), 32'(4'b0000));
        avoid_req = 1'b0;
        count_state(2'b10, n);
        check("dead_len", 32'(n), 32'd16);
        check("dead_exit_state", 32'(state_o), 32'(2'b01));
        check("dead_exit_motorIn", 32'(motorIn), 32'(4'b0101));
        step(1);
        check("held_line_gnt", 32'(line_gnt), 32'(1'b1));
        check("held_line_dead", 32'(state_o), 32'(2'b10));
        line_req = 1'b0;
        count_state(2'b10, n);
        check("dead2_len", 32'(n), 32'd16);
        check("dead2_motorIn", 32'(motorIn), 32'(4'b1010));

        // Coast on one pair is not a reversal
        avoid_req = 1'b1; avoid_cmd = 4'b1000;
        step(1);
        check("coast_gnt", 32'(avoid_gnt), 32'(1'b1));
        check("coast_state", 32'(state_o), 32'(2'b01));
        check("coast_motorIn", 32'(motorIn), 32'(4'b1000));
        avoid_req = 1'b0;

        // Red pulse during DEAD, then a glitch partway through the hold
        avoid_req = 1'b1; avoid_cmd = 4'b0100;
        step(1);
        check("pre_red_dead", 32'(state_o), 32'(2'b10));
        avoid_req = 1'b0;
        step(2);
        red = 1'b1;
        step(1);
        check("stop_state", 32'(state_o), 32'(2'b11));
        check("stop_motorIn", 32'(motorIn), 32'(4'b1111));
        check("stop_motorEn", 32'(motorEn), 32'(2'b11));
        red = 1'b0;
        step(29);
        check("stop_hold_mid", 32'(state_o), 32'(2'b11));
        red = 1'b1;
        step(1);
        red = 1'b0;
        count_state(2'b11, n);
        check("stop_len_after_glitch", 32'(n), 32'd64);
        check("stop_exit_state", 32'(state_o), 32'(2'b00));
        check("stop_exit_motorIn", 32'(motorIn), 32'(4'b0000));
        check("stop_exit_busy", 32'(busy), 32'(1'b0));

        // Duty 0 then 0x80 in RUN; cur_cmd was cleared so 1010 is not a reversal
        duty = 8'h00; line_req = 1'b1; line_cmd = 4'b1010;
        step(1);
        check("duty_run_state", 32'(state_o), 32'(2'b01));
        line_req = 1'b0;
        step(300);
        nz = 0;
        for (int i = 0; i < 256; i++) begin
            step(1);
            if (motorEn != 2'b00) nz++;
        end
        check("duty0_en_active", 32'(nz), 32'd0);
        duty = 8'h80;
        step(300);
        hi = 0; run = 1; maxrun = 1; prev = motorEn;
        for (int i = 0; i < 512; i++) begin
            step(1);
            if (motorEn == 2'b11) hi++;
            if (motorEn == prev) run++;
            else run = 1;
            if (run > maxrun) maxrun = run;
            prev = motorEn;
        end
        check("duty80_high_cycles", 32'(hi), 32'd256);
        check("duty80_run_len", 32'(maxrun), 32'd128);

        // Reset in cycle 5 of DEAD
        avoid_req = 1'b1; avoid_cmd = 4'b0101;
        step(1);
        avoid_req = 1'b0;
        step(4);
        check("rst_dead_pre", 32'(state_o), 32'(2'b10));
        reset = 1'b1;
        step(1);
        check("rst_dead_state", 32'(state_o), 32'(2'b00));
        check("rst_dead_motorIn", 32'(motorIn), 32'(4'b0000));
        check("rst_dead_busy", 32'(busy), 32'(1'b0));
        check("rst_dead_gnt", 32'({line_gnt, avoid_gnt}), 32'(2'b00));
        reset = 1'b0;
        step(30);
        check("rst_dead_no_pending", 32'(state_o), 32'(2'b00));
        check("rst_dead_no_pending_in", 32'(motorIn), 32'(4'b0000));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
